// File: rtl/dmem_resp_pkg.sv
// Shared constants and state encoding for the data-memory responder.
// Holds the bus widths, array geometry and FSM states used across dmem_resp.
package dmem_resp_pkg;

    localparam int DMEM_ADDR_W     = 64;
    localparam int DMEM_DATA_W     = 64;
    localparam int DMEM_MASK_W     = DMEM_DATA_W / 8;
    localparam int DMEM_DEPTH_LOG2 = 12;
    localparam int DMEM_CNT_W      = 4;
    localparam logic [DMEM_ADDR_W-1:0] DMEM_BASE = 64'h0000_0000_8000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dmem_state_e;

endpackage

// File: rtl/dmem_resp_sram.sv
// Single-port storage array with per-byte write enables and a registered read.
// Neither the contents nor the read register are reset.
module dmem_sram
    import dmem_resp_pkg::*;
#(
    parameter int DATA_W     = DMEM_DATA_W,
    parameter int DEPTH_LOG2 = DMEM_DEPTH_LOG2
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [DATA_W/8-1:0]   be,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata
);

    logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int b = 0; b < DATA_W / 8; b++) begin
                    if (be[b]) begin
                        mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
                    end
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/dmem_resp.sv
// Memory-side responder for MEM-stage doubleword loads/stores with configurable wait states.
// Owns the FSM, request latches, range check and sticky error; storage lives in dmem_sram.
module dmem_resp
    import dmem_resp_pkg::*;
#(
    parameter int                ADDR_W      = DMEM_ADDR_W,
    parameter int                DATA_W      = DMEM_DATA_W,
    parameter int                DEPTH_LOG2  = DMEM_DEPTH_LOG2,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = DMEM_BASE,
    parameter int                WAIT_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_W-1:0]     data_addr_i,
    input  logic [DATA_W/8-1:0]   wmask_i,
    input  logic [DATA_W-1:0]     data_i,
    input  logic                  we,
    input  logic                  re,
    output logic [DATA_W-1:0]     rdata_o,
    output logic                  mem_finish,
    output logic                  err_o
);

    localparam int MASK_W  = DATA_W / 8;
    localparam int OFF_LSB = DEPTH_LOG2 + 3;
    localparam logic [DMEM_CNT_W-1:0] WAIT_LOAD =
        (WAIT_CYCLES > 0) ? DMEM_CNT_W'(WAIT_CYCLES - 1) : '0;

    dmem_state_e             state_q, state_d;
    logic [DMEM_CNT_W-1:0]   wait_q;
    logic [ADDR_W-1:0]       addr_q;
    logic [MASK_W-1:0]       mask_q;
    logic [DATA_W-1:0]       data_q;
    logic                    wr_q;
    logic                    rd_valid_q;
    logic                    err_q;

    logic                    req;
    logic                    enter_resp;
    logic                    idle;
    logic                    sel_wr;
    logic                    in_range;
    logic                    sram_en;
    logic [ADDR_W-1:0]       sel_addr;
    logic [ADDR_W-1:0]       offset;
    logic [MASK_W-1:0]       sel_mask;
    logic [DATA_W-1:0]       sel_data;
    logic [DATA_W-1:0]       sram_q;
    logic [DEPTH_LOG2-1:0]   index;

    assign req = we | re;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (req) state_d = (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
            ST_WAIT: if (wait_q == '0) state_d = ST_RESP;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_finish = 1'b0;
        enter_resp = 1'b0;
        if (state_q == ST_RESP) mem_finish = 1'b1;
        if (state_d == ST_RESP) enter_resp = 1'b1;
    end

    // With zero wait states the array is accessed on the capture edge itself,
    // so the request fields come straight from the inputs while idle.
    always_comb begin
        idle     = (state_q == ST_IDLE);
        sel_addr = idle ? data_addr_i : addr_q;
        sel_mask = idle ? wmask_i     : mask_q;
        sel_data = idle ? data_i      : data_q;
        sel_wr   = idle ? we          : wr_q;
        offset   = sel_addr - BASE_ADDR;
        in_range = (sel_addr >= BASE_ADDR) && ((offset >> OFF_LSB) == '0);
        index    = offset[OFF_LSB-1:3];
        sram_en  = enter_resp && in_range && rst;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q     <= '0;
            mask_q     <= '0;
            data_q     <= '0;
            wr_q       <= 1'b0;
            wait_q     <= '0;
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            if (idle && req) begin
                addr_q <= data_addr_i;
                mask_q <= wmask_i;
                data_q <= data_i;
                wr_q   <= we;
                wait_q <= WAIT_LOAD;
            end else if (state_q == ST_WAIT && wait_q != '0) begin
                wait_q <= wait_q - DMEM_CNT_W'(1);
            end
            // rd_valid_q masks the unreset array register so reset and
            // out-of-range reads present zero until the next good read.
            if (enter_resp) begin
                if (!in_range) err_q <= 1'b1;
                if (!sel_wr)   rd_valid_q <= in_range;
            end
        end
    end

    dmem_sram #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_sram (
        .clk   (clk),
        .en    (sram_en),
        .we    (sel_wr),
        .be    (sel_mask),
        .addr  (index),
        .wdata (sel_data),
        .rdata (sram_q)
    );

    assign rdata_o = rd_valid_q ? sram_q : '0;
    assign err_o   = err_q;

endmodule

// File: tb/tb_dmem_resp.sv
// Directed bench for dmem_resp: three instances with 1, 0 and 3 wait states,
// a reference memory model and a scoreboard of expected completions.
module tb_dmem_resp;

    localparam logic [63:0] BASE = 64'h0000_0000_8000_0000;

    typedef struct {
        logic [63:0] rdata;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst_s   [3];
    logic [63:0] addr_s  [3];
    logic [7:0]  mask_s  [3];
    logic [63:0] data_s  [3];
    logic        we_s    [3];
    logic        re_s    [3];
    logic [63:0] rdata_s [3];
    logic        fin_s   [3];
    logic        err_s   [3];

    int          tests = 0;
    int          failures = 0;
    exp_t        sbq[$];
    logic [63:0] ref_mem[int];
    logic [63:0] last_rd [3];
    logic        exp_err [3];

    dmem_resp #(.WAIT_CYCLES(1)) u_dut_w1 (
        .clk(clk), .rst(rst_s[0]), .data_addr_i(addr_s[0]), .wmask_i(mask_s[0]),
        .data_i(data_s[0]), .we(we_s[0]), .re(re_s[0]), .rdata_o(rdata_s[0]),
        .mem_finish(fin_s[0]), .err_o(err_s[0]));

    dmem_resp #(.WAIT_CYCLES(0)) u_dut_w0 (
        .clk(clk), .rst(rst_s[1]), .data_addr_i(addr_s[1]), .wmask_i(mask_s[1]),
        .data_i(data_s[1]), .we(we_s[1]), .re(re_s[1]), .rdata_o(rdata_s[1]),
        .mem_finish(fin_s[1]), .err_o(err_s[1]));

    dmem_resp #(.WAIT_CYCLES(3)) u_dut_w3 (
        .clk(clk), .rst(rst_s[2]), .data_addr_i(addr_s[2]), .wmask_i(mask_s[2]),
        .data_i(data_s[2]), .we(we_s[2]), .re(re_s[2]), .rdata_o(rdata_s[2]),
        .mem_finish(fin_s[2]), .err_o(err_s[2]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("[TB] FAIL global_timeout: observed no end of run, required end before 400us");
        $fatal(1, "[TB] simulation time limit reached");
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drives one request, updates the model, then waits for the finish pulse
    // and compares latency, read data and error flag against the scoreboard.
    task automatic applyStimulus(input int k, input logic wr, input logic [63:0] addr,
                                 input logic [7:0] mask, input logic [63:0] data,
                                 input int lat);
        logic [63:0] off;
        logic        inr;
        int          key;
        int          n;
        logic        got;
        exp_t        e;
        off = addr - BASE;
        inr = (addr >= BASE) && (addr < BASE + 64'h8000);
        key = k * 65536 + int'(off[14:3]);
        if (wr) begin
            if (inr) begin
                if (!ref_mem.exists(key)) ref_mem[key] = '0;
                for (int b = 0; b < 8; b++)
                    if (mask[b]) ref_mem[key][b*8 +: 8] = data[b*8 +: 8];
            end
        end else begin
            last_rd[k] = inr ? ref_mem[key] : 64'h0;
        end
        if (!inr) exp_err[k] = 1'b1;
        e.rdata = last_rd[k];
        e.err   = exp_err[k];
        sbq.push_back(e);

        @(negedge clk);
        addr_s[k] = addr;
        mask_s[k] = mask;
        data_s[k] = data;
        we_s[k]   = wr;
        re_s[k]   = !wr;
        n   = 0;
        got = 1'b0;
        while (n < 40 && !got) begin
            @(posedge clk);
            #1;
            n++;
            if (fin_s[k]) got = 1'b1;
        end
        e = sbq.pop_front();
        checkOutput($sformatf("latency_dut%0d_%h", k, addr), 64'(n), 64'(lat));
        checkOutput($sformatf("rdata_dut%0d_%h", k, addr), rdata_s[k], e.rdata);
        checkOutput($sformatf("err_dut%0d_%h", k, addr), 64'(err_s[k]), 64'(e.err));
    endtask

    task automatic release_req(input int k);
        @(negedge clk);
        we_s[k] = 1'b0;
        re_s[k] = 1'b0;
        @(posedge clk);
        #1;
        checkOutput($sformatf("finish_one_cycle_dut%0d", k), 64'(fin_s[k]), 64'h0);
    endtask

    initial begin
        int          n_fin;
        logic [63:0] rnd;
        logic [63:0] val_a;

        for (int k = 0; k < 3; k++) begin
            rst_s[k]   = 1'b0;
            addr_s[k]  = BASE;
            mask_s[k]  = 8'hFF;
            data_s[k]  = 64'h5A5A_5A5A_5A5A_5A5A;
            we_s[k]    = 1'b1;
            re_s[k]    = 1'b0;
            last_rd[k] = 64'h0;
            exp_err[k] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("reset_finish_dut%0d", k), 64'(fin_s[k]), 64'h0);
            checkOutput($sformatf("reset_rdata_dut%0d", k), rdata_s[k], 64'h0);
            checkOutput($sformatf("reset_err_dut%0d", k), 64'(err_s[k]), 64'h0);
        end
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            we_s[k]  = 1'b0;
            rst_s[k] = 1'b1;
        end
        n_fin = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            for (int k = 0; k < 3; k++) if (fin_s[k]) n_fin++;
        end
        checkOutput("no_request_no_finish", 64'(n_fin), 64'h0);

        // One wait state: full store/load, byte store, mask-zero store, range errors.
        applyStimulus(0, 1'b1, 64'h8000_0010, 8'hFF, 64'h1122_3344_5566_7788, 2);
        release_req(0);
        applyStimulus(0, 1'b0, 64'h8000_0010, 8'h00, 64'h0, 2);
        release_req(0);
        applyStimulus(0, 1'b1, 64'h8000_0012, 8'b0000_0100, 64'h0000_0000_00AB_0000, 2);
        release_req(0);
        applyStimulus(0, 1'b0, 64'h8000_0010, 8'h00, 64'h0, 2);
        release_req(0);
        checkOutput("partial_write_value", rdata_s[0], 64'h1122_3344_55AB_7788);
        applyStimulus(0, 1'b1, 64'h8000_0000, 8'hFF, 64'hCAFE_F00D_0BAD_BEEF, 2);
        release_req(0);
        applyStimulus(0, 1'b1, 64'h8000_0000, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF, 2);
        release_req(0);
        applyStimulus(0, 1'b0, 64'h8000_0000, 8'h00, 64'h0, 2);
        release_req(0);
        applyStimulus(0, 1'b0, 64'h7FFF_FFF8, 8'h00, 64'h0, 2);
        release_req(0);
        applyStimulus(0, 1'b1, 64'h8000_8000, 8'hFF, 64'hDEAD_BEEF_DEAD_BEEF, 2);
        release_req(0);
        applyStimulus(0, 1'b0, 64'h8000_0000, 8'h00, 64'h0, 2);
        release_req(0);
        checkOutput("err_sticky", 64'(err_s[0]), 64'h1);

        // Zero wait states, back to back: the first request is presented while
        // idle, every later one during the previous response cycle.
        for (int i = 0; i < 16; i++) begin
            rnd = {$urandom(), $urandom()};
            applyStimulus(1, 1'b1, BASE + 64'(i * 8 + 64), 8'hFF, rnd, (i == 0) ? 1 : 2);
            applyStimulus(1, 1'b0, BASE + 64'((i >> 1) * 8 + 64), 8'h00, 64'h0, 2);
        end
        release_req(1);
        checkOutput("b2b_no_err", 64'(err_s[1]), 64'h0);

        // Three wait states with a reset pulse in the second wait cycle.
        val_a = 64'h0123_4567_89AB_CDEF;
        applyStimulus(2, 1'b1, 64'h8000_0100, 8'hFF, val_a, 4);
        release_req(2);
        applyStimulus(2, 1'b0, 64'h8000_0100, 8'h00, 64'h0, 4);
        release_req(2);
        @(negedge clk);
        addr_s[2] = 64'h8000_0100;
        mask_s[2] = 8'hFF;
        data_s[2] = 64'hFEDC_BA98_7654_3210;
        we_s[2]   = 1'b1;
        re_s[2]   = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_s[2] = 1'b0;
        we_s[2]  = 1'b0;
        #1;
        checkOutput("midreset_finish", 64'(fin_s[2]), 64'h0);
        checkOutput("midreset_rdata", rdata_s[2], 64'h0);
        checkOutput("midreset_err", 64'(err_s[2]), 64'h0);
        #1;
        rst_s[2]   = 1'b1;
        last_rd[2] = 64'h0;
        exp_err[2] = 1'b0;
        n_fin = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (fin_s[2]) n_fin++;
        end
        checkOutput("midreset_no_finish", 64'(n_fin), 64'h0);
        applyStimulus(2, 1'b0, 64'h8000_0100, 8'h00, 64'h0, 4);
        release_req(2);
        checkOutput("midreset_location_kept", rdata_s[2], val_a);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
